mem_stage: RTL and testbench

- Pipeline MEM stage between EX and WB.
- Holds the EX→MEM payload and waits for the data-SRAM response of the load or store that EX issued.
- Extracts and merges load data (LB/LBU/LH/LHU/LW/LWL/LWR) and produces the 130-bit MS_TO_WS bus consumed by WB.
- Cancels in-flight responses on an exception/ERET flush, and drives the hazard-stall and forwarding buses to ID.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_load_align.sv | 49 ++++
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------
// mem_stage_pkg: bus widths, field offsets and load-op codes. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 167;
  localparam int MS_TO_WS_BUS_WD = 130;
  localparam int STALL_BUS_WD    = 11;
  localparam int FORWARD_BUS_WD  = 33;

  // EX->MEM bus fields
  localparam int ES_MEM_REQ      = 166;
  localparam int ES_LOAD_OP_LO   = 163;
  localparam int ES_RT_VALUE_LO  = 131;
  localparam int ES_RES_FROM_MEM = 130;

  // MEM->WB payload fields
  localparam int WS_ERET      = 42;
  localparam int WS_EXC       = 41;
  localparam int WS_GR_WE_LO  = 37;
  localparam int WS_DEST_LO   = 32;
  localparam int WS_RESULT_LO = 0;

  typedef enum logic [2:0] {
    LOAD_OP_LW  = 3'd0,
    LOAD_OP_LB  = 3'd1,
    LOAD_OP_LBU = 3'd2,
    LOAD_OP_LH  = 3'd3,
    LOAD_OP_LHU = 3'd4,
    LOAD_OP_LWL = 3'd5,
    LOAD_OP_LWR = 3'd6
  } load_op_e;

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// ---------------------------------------------------------------------
// mem_load_align: load data extraction and rt merge. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  input  logic [31:0] rt_value,
  output logic [31:0] result,
  output logic [3:0]  gr_we
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] shifted;

  always_comb begin
    byte_sel = data[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? data[31:16] : data[15:0];
    shifted  = data;
    gr_we    = 4'b1111;
    case (load_op)
      LOAD_OP_LB:  shifted = {{24{byte_sel[7]}}, byte_sel};
      LOAD_OP_LBU: shifted = {24'd0, byte_sel};
      LOAD_OP_LH:  shifted = {{16{half_sel[15]}}, half_sel};
      LOAD_OP_LHU: shifted = {16'd0, half_sel};
      // ~addr == 3-addr for a 2-bit address
      LOAD_OP_LWL: begin
        shifted = data << {~addr, 3'b000};
        gr_we   = 4'b1111 << ~addr;
      end
      LOAD_OP_LWR: begin
        shifted = data >> {addr, 3'b000};
        gr_we   = 4'b1111 >> addr;
      end
      default: shifted = data;
    endcase
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = gr_we[i] ? shifted[8*i +: 8] : rt_value[8*i +: 8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------
// mem_stage: pipeline MEM stage between EX and WB. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       es_mem_inflight,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [STALL_BUS_WD-1:0]    stall_ms_bus,
  output logic [FORWARD_BUS_WD-1:0]  forward_ms_bus,
  output logic                       ms_exc_eret
);

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] payload_r;
  logic                       rdata_buf_valid;
  logic [31:0]                rdata_buf;
  logic [1:0]                 cancel_cnt;

  logic                       mem_req;
  logic [2:0]                 load_op;
  logic [31:0]                rt_value;
  logic                       res_from_mem;
  logic [MS_TO_WS_BUS_WD-1:0] payload;
  logic [31:0]                alu_result;
  logic [3:0]                 gr_we_in;
  logic [4:0]                 dest;

  logic                       resp_ok;
  logic                       ms_ready_go;
  logic                       ms_leave;
  logic [31:0]                load_data;
  logic [31:0]                load_result;
  logic [3:0]                 load_gr_we;
  logic [31:0]                final_result;
  logic [3:0]                 final_gr_we;
  logic                       load_pending;
  logic                       cancel_dec;
  logic [2:0]                 cancel_sum;
  logic [1:0]                 cancel_next;

  assign mem_req      = payload_r[ES_MEM_REQ];
  assign load_op      = payload_r[ES_LOAD_OP_LO +: 3];
  assign rt_value     = payload_r[ES_RT_VALUE_LO +: 32];
  assign res_from_mem = payload_r[ES_RES_FROM_MEM];
  assign payload      = payload_r[MS_TO_WS_BUS_WD-1:0];
  assign alu_result   = payload[WS_RESULT_LO +: 32];
  assign gr_we_in     = payload[WS_GR_WE_LO +: 4];
  assign dest         = payload[WS_DEST_LO +: 5];

  // Responses owed to flushed instructions are swallowed first
  assign resp_ok        = data_sram_data_ok && (cancel_cnt == 2'd0);
  assign ms_ready_go    = !mem_req || rdata_buf_valid || resp_ok;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
  assign ms_leave       = ms_to_ws_valid && ws_allowin;
  assign load_data      = rdata_buf_valid ? rdata_buf : data_sram_rdata;

  mem_load_align u_align (
    .load_op  (load_op),
    .addr     (alu_result[1:0]),
    .data     (load_data),
    .rt_value (rt_value),
    .result   (load_result),
    .gr_we    (load_gr_we)
  );

  assign final_result = res_from_mem ? load_result : alu_result;
  assign final_gr_we  = res_from_mem ? load_gr_we  : gr_we_in;
  assign load_pending = ms_valid && res_from_mem && !ms_ready_go;

  always_comb begin
    ms_to_ws_bus                       = payload;
    ms_to_ws_bus[WS_GR_WE_LO +: 4]     = final_gr_we;
    ms_to_ws_bus[WS_RESULT_LO +: 32]   = final_result;
  end

  assign stall_ms_bus   = {ms_valid && |final_gr_we, final_gr_we, dest, load_pending};
  assign forward_ms_bus = {ms_valid && !(res_from_mem && !ms_ready_go), final_result};
  assign ms_exc_eret    = ms_valid && (payload[WS_EXC] || payload[WS_ERET]);

  // On flush, count the MEM and EX requests whose responses are still owed
  assign cancel_dec  = data_sram_data_ok && (cancel_cnt != 2'd0);
  assign cancel_sum  = {1'b0, cancel_cnt}
                     + {2'b00, flush && ms_valid && mem_req && !rdata_buf_valid}
                     + {2'b00, flush && es_mem_inflight}
                     - {2'b00, cancel_dec};
  assign cancel_next = (cancel_sum > 3'd3) ? 2'd3 : cancel_sum[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid        <= 1'b0;
      payload_r       <= '0;
      rdata_buf_valid <= 1'b0;
      rdata_buf       <= 32'd0;
      cancel_cnt      <= 2'd0;
    end else begin
      if (flush) begin
        ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        payload_r <= es_to_ms_bus;
      end
      if (flush || ms_leave) begin
        rdata_buf_valid <= 1'b0;
      end else if (ms_valid && mem_req && resp_ok && !ws_allowin) begin
        rdata_buf_valid <= 1'b1;
        rdata_buf       <= data_sram_rdata;
      end
      cancel_cnt <= cancel_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------
// tb_mem_stage: vector table plus scoreboard bench for mem_stage. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                       clk;
  logic                       resetn;
  logic                       flush;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic                       es_mem_inflight;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;
  logic                       ws_allowin;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [STALL_BUS_WD-1:0]    stall_ms_bus;
  logic [FORWARD_BUS_WD-1:0]  forward_ms_bus;
  logic                       ms_exc_eret;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .flush             (flush),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .es_mem_inflight   (es_mem_inflight),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .stall_ms_bus      (stall_ms_bus),
    .forward_ms_bus    (forward_ms_bus),
    .ms_exc_eret       (ms_exc_eret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mem_req;
    logic        res_from_mem;
    logic [2:0]  load_op;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic [3:0]  we_in;
    logic        exc;
    logic [31:0] exp_res;
    logic [3:0]  exp_we;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  logic [MS_TO_WS_BUS_WD-1:0] sb[$];
  logic [MS_TO_WS_BUS_WD-1:0] exp_bus;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted MEM->WB transfer must match the oldest expectation
  always @(negedge clk) begin
    if (resetn && ms_to_ws_valid && ws_allowin) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL ws_bus_unexpected: got %h expected none", ms_to_ws_bus);
      end else begin
        exp_bus = sb.pop_front();
        if (ms_to_ws_bus !== exp_bus) begin
          errors++;
          $display("FAIL ws_bus: got %h expected %h", ms_to_ws_bus, exp_bus);
        end
      end
    end
  end

  // Builds the EX bus for a vector and the WB bus it should produce
  task automatic make_bus(input vec_t v, input logic [4:0] dest,
                          output logic [ES_TO_MS_BUS_WD-1:0] bus,
                          output logic [MS_TO_WS_BUS_WD-1:0] wb);
    logic [95:0] filler;
    filler = {$urandom, $urandom, $urandom};
    bus = {v.mem_req, v.load_op, v.rt, v.res_from_mem,
           filler[86:0], 1'b0, v.exc, v.we_in, dest, v.alu};
    wb  = {filler[86:0], 1'b0, v.exc, v.exp_we, dest, v.exp_res};
  endtask

  task automatic issue(input logic [ES_TO_MS_BUS_WD-1:0] bus,
                       input logic [MS_TO_WS_BUS_WD-1:0] wb, input bit push);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    if (push) sb.push_back(wb);
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic [4:0] dest;
    logic [ES_TO_MS_BUS_WD-1:0] bus;
    logic [MS_TO_WS_BUS_WD-1:0] wb;
    v    = vecs[i];
    dest = 5'(i + 3);
    make_bus(v, dest, bus, wb);
    chk({v.name, "_allowin"}, 64'(ms_allowin), 64'd1);
    issue(bus, wb, 1'b1);
    #1;
    if (!v.mem_req) begin
      chk({v.name, "_valid"}, 64'(ms_to_ws_valid), 64'd1);
      chk({v.name, "_exc_eret"}, 64'(ms_exc_eret), 64'(v.exc));
    end else begin
      chk({v.name, "_wait_valid"}, 64'(ms_to_ws_valid), 64'd0);
      chk({v.name, "_stall_bus"}, 64'(stall_ms_bus),
          64'({|v.exp_we, v.exp_we, dest, v.res_from_mem}));
      tick();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = v.rdata;
      #1;
      chk({v.name, "_pending_done"}, 64'(stall_ms_bus[0]), 64'd0);
      chk({v.name, "_forward"}, 64'(forward_ms_bus), 64'({1'b1, v.exp_res}));
      tick();
      data_sram_data_ok = 1'b0;
    end
  endtask

  initial begin
    logic [ES_TO_MS_BUS_WD-1:0] bus;
    logic [MS_TO_WS_BUS_WD-1:0] wb;
    vec_t lw;

    //          name     mreq rfm op           alu           rt            rdata         we_in    exc  exp_res       exp_we
    vecs[0]  = '{"add",   0, 0, LOAD_OP_LW,  32'h12345678, 32'h0,        32'h0,        4'b1111, 0, 32'h12345678, 4'b1111};
    vecs[1]  = '{"lb3",   1, 1, LOAD_OP_LB,  32'h00001003, 32'h11223344, 32'h80AA55CC, 4'b1111, 0, 32'hFFFFFF80, 4'b1111};
    vecs[2]  = '{"lbu3",  1, 1, LOAD_OP_LBU, 32'h00001003, 32'h11223344, 32'h80AA55CC, 4'b1111, 0, 32'h00000080, 4'b1111};
    vecs[3]  = '{"lb0",   1, 1, LOAD_OP_LB,  32'h00001000, 32'h11223344, 32'h80AA55CC, 4'b1111, 0, 32'hFFFFFFCC, 4'b1111};
    vecs[4]  = '{"lh2",   1, 1, LOAD_OP_LH,  32'h00001002, 32'h11223344, 32'h80AA55CC, 4'b1111, 0, 32'hFFFF80AA, 4'b1111};
    vecs[5]  = '{"lhu0",  1, 1, LOAD_OP_LHU, 32'h00001000, 32'h11223344, 32'h80AA55CC, 4'b1111, 0, 32'h000055CC, 4'b1111};
    vecs[6]  = '{"lw",    1, 1, LOAD_OP_LW,  32'h00001000, 32'h11223344, 32'hDEADBEEF, 4'b1111, 0, 32'hDEADBEEF, 4'b1111};
    vecs[7]  = '{"lwl1",  1, 1, LOAD_OP_LWL, 32'h00001001, 32'h11223344, 32'hAABBCCDD, 4'b1111, 0, 32'hCCDD3344, 4'b1100};
    vecs[8]  = '{"lwr1",  1, 1, LOAD_OP_LWR, 32'h00001001, 32'h11223344, 32'hAABBCCDD, 4'b1111, 0, 32'h11AABBCC, 4'b0111};
    vecs[9]  = '{"lwl3",  1, 1, LOAD_OP_LWL, 32'h00001003, 32'h11223344, 32'hAABBCCDD, 4'b1111, 0, 32'hAABBCCDD, 4'b1111};
    vecs[10] = '{"lwl0",  1, 1, LOAD_OP_LWL, 32'h00001000, 32'h11223344, 32'hAABBCCDD, 4'b1111, 0, 32'hDD223344, 4'b1000};
    vecs[11] = '{"lwr0",  1, 1, LOAD_OP_LWR, 32'h00001000, 32'h11223344, 32'hAABBCCDD, 4'b1111, 0, 32'hAABBCCDD, 4'b1111};
    vecs[12] = '{"lwr3",  1, 1, LOAD_OP_LWR, 32'h00001003, 32'h11223344, 32'hAABBCCDD, 4'b1111, 0, 32'h112233AA, 4'b0001};
    vecs[13] = '{"store", 1, 0, LOAD_OP_LW,  32'h00002000, 32'h55667788, 32'h0,        4'b0000, 0, 32'h00002000, 4'b0000};
    vecs[14] = '{"exc",   0, 0, LOAD_OP_LW,  32'hBFC00380, 32'h0,        32'h0,        4'b0000, 1, 32'hBFC00380, 4'b0000};

    resetn = 1'b0; flush = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    es_mem_inflight = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
    ws_allowin = 1'b1;
    #3;
    chk("rst_valid",    64'(ms_to_ws_valid),     64'd0);
    chk("rst_allowin",  64'(ms_allowin),         64'd1);
    chk("rst_exc_eret", 64'(ms_exc_eret),        64'd0);
    chk("rst_stall",    64'(stall_ms_bus[10]),   64'd0);
    chk("rst_forward",  64'(forward_ms_bus[32]), 64'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) run_vec(i);
    tick();

    // Response arrives while WB is stalled; buffered data must be used later
    lw = vecs[6];
    make_bus(lw, 5'd20, bus, wb);
    issue(bus, wb, 1'b1);
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEADBEEF;
    #1;
    chk("buf_ready", 64'(ms_to_ws_valid), 64'd1);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    #1;
    chk("buf_hold_valid",   64'(ms_to_ws_valid), 64'd1);
    chk("buf_hold_forward", 64'(forward_ms_bus), 64'({1'b1, 32'hDEADBEEF}));
    chk("buf_hold_allowin", 64'(ms_allowin),     64'd0);
    tick();
    ws_allowin = 1'b1;
    tick();
    chk("buf_drained", 64'(sb.size()), 64'd0);

    // Flush with MEM and EX both waiting: two responses must be dropped
    make_bus(lw, 5'd21, bus, wb);
    issue(bus, wb, 1'b0);
    es_mem_inflight = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_valid", 64'(ms_to_ws_valid), 64'd0);
    tick();
    flush = 1'b0;
    es_mem_inflight = 1'b0;
    #1;
    chk("cancel_cnt_2",  64'(dut.cancel_cnt), 64'd2);
    chk("flush_allowin", 64'(ms_allowin),     64'd1);
    lw.rdata = 32'hCAFEF00D; lw.exp_res = 32'hCAFEF00D;
    make_bus(lw, 5'd22, bus, wb);
    issue(bus, wb, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBAD00001;
    #1;
    chk("cancel_drop1", 64'(ms_to_ws_valid), 64'd0);
    tick();
    data_sram_rdata = 32'hBAD00002;
    #1;
    chk("cancel_drop2", 64'(ms_to_ws_valid), 64'd0);
    tick();
    data_sram_rdata = 32'hCAFEF00D;
    #1;
    chk("cancel_accept", 64'(ms_to_ws_valid), 64'd1);
    tick();
    data_sram_data_ok = 1'b0;
    chk("cancel_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset while a load waits and a cancel is outstanding
    es_mem_inflight = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    es_mem_inflight = 1'b0;
    make_bus(lw, 5'd23, bus, wb);
    issue(bus, wb, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid",   64'(ms_to_ws_valid),  64'd0);
    chk("async_rst_allowin", 64'(ms_allowin),      64'd1);
    chk("async_rst_cancel",  64'(dut.cancel_cnt),  64'd0);
    tick();
    resetn = 1'b1;
    tick();

    run_vec(0);
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
